// File: rtl/cipher_pkg.sv
// Shared constants and encodings for the receive-side block assembler.
package cipher_pkg;
   localparam int BYTE_W = 8;
   localparam int BLK_W  = 64;

   typedef enum logic {FILL, FULL} asm_state_t;

   localparam logic MODE_ENCRYPT = 1'b1;
   localparam logic MODE_DECRYPT = 1'b0;
endpackage

// File: rtl/byte_shift_reg.sv
// Shift-in register of N lanes of W bits; new data enters lane 0 (LSBs) and
// older bytes move toward the MSB end.
module byte_shift_reg #(
   parameter int W = 8,
   parameter int N = 8
) (
   input  logic           clk,
   input  logic           n_reset,
   input  logic           clr,
   input  logic           load,
   input  logic [W-1:0]   din,
   output logic [W*N-1:0] dout
);
   for (genvar gi = 0; gi < N; gi++) begin : g_lane
      logic [W-1:0] src;
      logic [W-1:0] lane_reg;

      if (gi == 0) begin : g_head
         assign src = din;
      end else begin : g_tail
         assign src = dout[(gi-1)*W +: W];
      end

      always_ff @(posedge clk or negedge n_reset) begin
         if (!n_reset)
            lane_reg <= '0;
         else if (clr)
            lane_reg <= '0;
         else if (load)
            lane_reg <= src;
      end

      assign dout[gi*W +: W] = lane_reg;
   end
endmodule

// File: rtl/rx_block_assembler.sv
// Packs MCU-strobed Rx FIFO bytes MSB-first into cipher blocks and hands each
// completed block, with the mode captured at its first byte, to the cipher core.
module rx_block_assembler #(
   parameter int BYTE_W        = 8,
   parameter int BYTES_PER_BLK = 8
) (
   input  logic                            clk,
   input  logic                            n_reset,
   input  logic                            read_fifo,
   input  logic [BYTE_W-1:0]               rx_data,
   input  logic                            is_encrypt,
   input  logic                            clear,
   output logic                            accepted,
   output logic                            blk_valid,
   output logic [BYTE_W*BYTES_PER_BLK-1:0] blk_data,
   output logic                            blk_encrypt,
   input  logic                            blk_ready,
   output logic [3:0]                      byte_cnt
);
   import cipher_pkg::*;

   asm_state_t                        state_reg;
   logic                              mode_reg;
   logic [BYTE_W*BYTES_PER_BLK-1:0]   asm_data;
   logic                              shift_en;
   logic                              slot_free;

   assign shift_en  = (state_reg == FILL) && read_fifo && !clear;
   assign slot_free = !blk_valid || blk_ready;

   byte_shift_reg #(.W(BYTE_W), .N(BYTES_PER_BLK)) u_asm (
      .clk     (clk),
      .n_reset (n_reset),
      .clr     (clear),
      .load    (shift_en),
      .din     (rx_data),
      .dout    (asm_data)
   );

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_reg   <= FILL;
         mode_reg    <= MODE_DECRYPT;
         byte_cnt    <= 4'd0;
         accepted    <= 1'b0;
         blk_valid   <= 1'b0;
         blk_data    <= '0;
         blk_encrypt <= 1'b0;
      end else if (clear) begin
         state_reg <= FILL;
         byte_cnt  <= 4'd0;
         accepted  <= 1'b0;
         blk_valid <= 1'b0;
      end else begin
         accepted <= shift_en;
         case (state_reg)
            FILL: begin
               if (read_fifo) begin
                  byte_cnt <= byte_cnt + 4'd1;
                  if (byte_cnt == 4'd0)
                     mode_reg <= is_encrypt;
                  if (byte_cnt == 4'(BYTES_PER_BLK - 1))
                     state_reg <= FULL;
               end
               if (blk_valid && blk_ready)
                  blk_valid <= 1'b0;
            end
            FULL: begin
               // A consumed slot is refilled at the same edge, so valid never gaps.
               if (slot_free) begin
                  blk_data    <= asm_data;
                  blk_encrypt <= mode_reg;
                  blk_valid   <= 1'b1;
                  byte_cnt    <= 4'd0;
                  state_reg   <= FILL;
               end
            end
            default: state_reg <= FILL;
         endcase
      end
   end
endmodule

// File: tb/tb_rx_block_assembler.sv
// Self-checking bench: directed scenarios plus random traffic against a
// queue-based model of the assembler and its one-deep output slot.
module tb_rx_block_assembler;
   logic        clk = 1'b0;
   logic        n_reset = 1'b0;
   logic        read_fifo = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        is_encrypt = 1'b0;
   logic        clear = 1'b0;
   logic        accepted;
   logic        blk_valid;
   logic [63:0] blk_data;
   logic        blk_encrypt;
   logic        blk_ready = 1'b0;
   logic [3:0]  byte_cnt;

   int checks = 0;
   int errors = 0;

   // model state
   logic [7:0]  m_q[$];
   logic        m_mode = 1'b0;
   logic        m_acc = 1'b0;
   logic        m_sv = 1'b0;
   logic [63:0] m_data = 64'h0;
   logic        m_enc = 1'b0;

   rx_block_assembler dut (
      .clk         (clk),
      .n_reset     (n_reset),
      .read_fifo   (read_fifo),
      .rx_data     (rx_data),
      .is_encrypt  (is_encrypt),
      .clear       (clear),
      .accepted    (accepted),
      .blk_valid   (blk_valid),
      .blk_data    (blk_data),
      .blk_encrypt (blk_encrypt),
      .blk_ready   (blk_ready),
      .byte_cnt    (byte_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] pack_bytes(input logic [7:0] b[$]);
      logic [63:0] r = 64'h0;
      foreach (b[i]) r = {r[55:0], b[i]};
      return r;
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_mode = 1'b0;
      m_acc  = 1'b0;
      m_sv   = 1'b0;
      m_data = 64'h0;
      m_enc  = 1'b0;
   endtask

   task automatic compare(input string tag);
      chk({tag, ".accepted"},  {63'h0, accepted},  {63'h0, m_acc});
      chk({tag, ".blk_valid"}, {63'h0, blk_valid}, {63'h0, m_sv});
      chk({tag, ".byte_cnt"},  {60'h0, byte_cnt},  64'(m_q.size()));
      if (m_sv) begin
         chk({tag, ".blk_data"},    blk_data, m_data);
         chk({tag, ".blk_encrypt"}, {63'h0, blk_encrypt}, {63'h0, m_enc});
      end
   endtask

   // One clock cycle: drive inputs, advance model at the edge, compare after it.
   task automatic step(input logic rf, input logic [7:0] d, input logic enc,
                       input logic clr, input logic rdy, input string tag);
      logic take;
      read_fifo  = rf;
      rx_data    = d;
      is_encrypt = enc;
      clear      = clr;
      blk_ready  = rdy;
      @(posedge clk);
      if (clr) begin
         m_q.delete();
         m_acc = 1'b0;
         m_sv  = 1'b0;
      end else begin
         take = rf && (m_q.size() < 8);
         if (m_q.size() == 8 && (!m_sv || rdy)) begin
            m_data = pack_bytes(m_q);
            m_enc  = m_mode;
            m_sv   = 1'b1;
            m_q.delete();
         end else if (m_sv && rdy) begin
            m_sv = 1'b0;
         end
         if (take) begin
            if (m_q.size() == 0) m_mode = enc;
            m_q.push_back(d);
         end
         m_acc = take;
      end
      #1;
      compare(tag);
   endtask

   task automatic idle(input logic rdy, input string tag);
      step(1'b0, 8'h00, 1'b0, 1'b0, rdy, tag);
   endtask

   task automatic async_reset();
      n_reset = 1'b0;
      #2;
      model_reset();
      chk("rst.accepted",    {63'h0, accepted},    64'h0);
      chk("rst.blk_valid",   {63'h0, blk_valid},   64'h0);
      chk("rst.blk_data",    blk_data,             64'h0);
      chk("rst.blk_encrypt", {63'h0, blk_encrypt}, 64'h0);
      chk("rst.byte_cnt",    {60'h0, byte_cnt},    64'h0);
      @(posedge clk);
      #1;
      n_reset = 1'b1;
   endtask

   initial begin
      logic [7:0] pin[$];
      for (int i = 1; i <= 8; i++) pin.push_back(8'(i));
      chk("model.pack", pack_bytes(pin), 64'h0102030405060708);

      @(posedge clk);
      #1;
      async_reset();

      // Basic block with immediate sink
      for (int i = 1; i <= 8; i++) step(1'b1, 8'(i), 1'b1, 1'b0, 1'b1, "t1.fill");
      chk("t1.cnt_full", {60'h0, byte_cnt}, 64'd8);
      idle(1'b1, "t1.xfer");
      chk("t1.blk_data", blk_data, 64'h0102030405060708);
      chk("t1.blk_enc", {63'h0, blk_encrypt}, 64'h1);
      idle(1'b1, "t1.drain");

      // Back-pressure: second block waits in FULL, 17th strobe rejected
      for (int i = 0; i < 8; i++) step(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0, "t2.fillA");
      idle(1'b0, "t2.xferA");
      for (int i = 0; i < 8; i++) step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0, "t2.fill5");
      step(1'b1, 8'h99, 1'b0, 1'b0, 1'b0, "t2.strobe17");
      chk("t2.rej_acc", {63'h0, accepted}, 64'h0);
      chk("t2.rej_cnt", {60'h0, byte_cnt}, 64'd8);
      chk("t2.holdA",   blk_data, 64'hAAAAAAAAAAAAAAAA);
      idle(1'b1, "t2.swap");
      chk("t2.valid_nogap", {63'h0, blk_valid}, 64'h1);
      chk("t2.block5", blk_data, 64'h5555555555555555);
      idle(1'b1, "t2.drain");

      // Mode change mid-block affects only the following block
      for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h30 + i), (i < 3), 1'b0, 1'b1, "t3.fill1");
      idle(1'b1, "t3.xfer1");
      chk("t3.enc_first", {63'h0, blk_encrypt}, 64'h1);
      for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b1, "t3.fill2");
      idle(1'b1, "t3.xfer2");
      chk("t3.enc_second", {63'h0, blk_encrypt}, 64'h0);
      idle(1'b1, "t3.drain");

      // Clear discards a partial block and the coincident strobe
      for (int i = 0; i < 5; i++) step(1'b1, 8'hEE, 1'b1, 1'b0, 1'b1, "t4.part");
      step(1'b1, 8'hEE, 1'b1, 1'b1, 1'b1, "t4.clear");
      chk("t4.cnt", {60'h0, byte_cnt}, 64'h0);
      chk("t4.acc", {63'h0, accepted}, 64'h0);
      for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b1, "t4.fill");
      idle(1'b1, "t4.xfer");
      chk("t4.clean", blk_data, 64'h1011121314151617);
      idle(1'b1, "t4.drain");

      // Asynchronous reset mid-block
      for (int i = 0; i < 4; i++) step(1'b1, 8'hCC, 1'b1, 1'b0, 1'b1, "t5.part");
      async_reset();
      for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h21 + i), 1'b1, 1'b0, 1'b1, "t5.fill");
      idle(1'b1, "t5.xfer");
      chk("t5.fresh", blk_data, 64'h2122232425262728);

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         step(($urandom_range(0, 9) < 7), 8'($urandom), 1'($urandom),
              ($urandom_range(0, 49) == 0), 1'($urandom), "rnd");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/rx_block_assembler.md
# rx_block_assembler

Sits between the receive FIFO and the cipher core, downstream of the MCU's data-read handshake. Captures one byte per MCU `read_fifo` strobe and packs bytes MSB-first into 64-bit blocks. Answers every strobe with a one-cycle `accepted` pulse or with silence. Presents each completed block, with its encrypt/decrypt mode, to the cipher core over a valid/ready handshake.

## Interface
- `BYTE_W`, 8, width of one FIFO entry.
- `BYTES_PER_BLK`, 8, bytes per cipher block; block width = `BYTE_W*BYTES_PER_BLK` (64).
- `clk`  in  1  system clock, rising edge.
- `n_reset`  in  1  asynchronous, active-low reset.
- `read_fifo`  in  1  MCU strobe: head byte of the Rx FIFO is valid on `rx_data` this cycle.
- `rx_data`  in  `BYTE_W`  Rx FIFO head byte.
- `is_encrypt`  in  1  current MCU mode (1 = encrypt, 0 = decrypt).
- `clear`  in  1  synchronous flush of partial and pending blocks.
- `accepted`  out  1  one-cycle pulse in the cycle after an accepted `read_fifo`.
- `blk_valid`  out  1  output block pending for the cipher core.
- `blk_data`  out  64  output block; byte 0 in [63:56].
- `blk_encrypt`  out  1  mode bound to the output block.
- `blk_ready`  in  1  cipher core takes the block when `blk_valid` and `blk_ready` are both high.
- `byte_cnt`  out  4  bytes held in the assembly register (0..8).

## Operation
- Reset values: `accepted`=0, `blk_valid`=0, `blk_data`=0, `blk_encrypt`=0, `byte_cnt`=0. The assembly register is also cleared, and the assembler FSM enters FILL.
- Assembler FSM, FILL and FULL.
  - FILL (`byte_cnt` < 8): when `read_fifo` is high, shift `rx_data` in: `asm <= {asm[55:0], rx_data}`, `byte_cnt`+1, and set `accepted` for the next cycle.
  - If `byte_cnt`==0 at the time of the accept, latch `is_encrypt` into the block mode. A mode change mid-block does not affect that block.
  - The 8th accept moves the FSM to FULL.
  - FULL (`byte_cnt`==8): `read_fifo` is ignored and `accepted` stays 0 next cycle. The MCU re-strobes.
- Output slot, EMPTY or VALID.
  - In FULL, when the slot is EMPTY, or is VALID with `blk_ready` high in the same cycle: copy `asm` to `blk_data` and the latched mode to `blk_encrypt`; set `blk_valid`=1, `byte_cnt`=0; the FSM returns to FILL.
  - `blk_valid` drops only on a valid && ready handshake with no simultaneous refill.
  - `blk_data` and `blk_encrypt` stay stable while `blk_valid`=1 and `blk_ready`=0.
- `accepted` is never high for two consecutive cycles unless `read_fifo` was high in two consecutive accepted cycles.
- `clear` is synchronous and has top priority over `read_fifo` and the transfer.
  - It sets `byte_cnt`=0, `blk_valid`=0, `accepted`=0, FSM = FILL.
  - It discards any partial block and any pending output block.
- Asynchronous reset mid-block discards all data. No partial block survives.

## Timing
- `read_fifo` accepted in cycle T → `accepted`=1 in T+1 only. This matches the MCU sampling `accepted` in the state that follows its read strobe.
- 8th byte accepted in T → `byte_cnt`=8 in T+1 → `blk_valid`=1 in T+2 if the slot was empty. A `read_fifo` in T+1 is rejected; this is the one-cycle bubble.
- Slot VALID with `blk_ready` held low: the FSM stays in FULL and every strobe is rejected. Back-pressure reaches the MCU through missing `accepted`.
- `blk_ready` high in the same cycle the FSM is in FULL: the old block is consumed and the new block is loaded at that edge. `blk_valid` stays 1 with no gap.
- `clear` and `read_fifo` in the same cycle: the byte is not taken and `accepted`=0 next cycle.

## Structure
- Shared package `cipher_pkg`:
  - `BYTE_W` and `BLK_W` constants.
  - The assembler state enum {FILL, FULL}.
  - The mode encoding (1 = encrypt).
- One sub-module is natural: `byte_shift_reg`, a parameterised shift-in register with load enable and synchronous clear. The FSM and the output slot stay in the top level.

## Test plan
- Reset, then 8 strobes with `rx_data`=0x01..0x08 and `is_encrypt`=1, with `blk_ready`=1:
  - `accepted` follows each strobe by one cycle.
  - `blk_data`=0x0102030405060708 and `blk_encrypt`=1, two cycles after the 8th strobe.
- With `blk_ready`=0, fill two blocks (0xAA×8 then 0x55×8) and then strobe a 17th byte:
  - The second block waits in FULL; the 17th strobe gets no `accepted` and `byte_cnt`=8.
  - `blk_data`=0xAAAA…AA stays stable until `blk_ready`=1, then 0x5555…55 appears with no `blk_valid` gap.
- Switch `is_encrypt` 1→0 after byte 3 of a block → that block has `blk_encrypt`=1; the next block has `blk_encrypt`=0.
- Strobe 5 bytes, then `clear` together with a strobe → `byte_cnt`=0, no `accepted`; the next 8 bytes form a clean block.
- Assert `n_reset` low after byte 4 → all outputs return to their reset values; the next block is assembled from fresh bytes only.
